// File: rtl/barrier_alloc_ctrl.sv
// rtl/barrier_alloc_ctrl.sv - barrier allocator: picks a free barrier and programs its masks over the bus
// Optional BARR_ALLOC_CLR_ON_FREE_EN: a freed barrier is cleared over the bus before it is released.
module barrier_alloc_ctrl #(
  parameter int          NB_CORES  = 8,
  parameter int          NB_BARR   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         IDW       = (NB_BARR > 1) ? $clog2(NB_BARR) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                alloc_req_i,
  input  logic [NB_CORES-1:0] alloc_trig_mask_i,
  input  logic [NB_CORES-1:0] alloc_tgt_mask_i,
  output logic                alloc_gnt_o,
  output logic                alloc_done_o,
  output logic                alloc_fail_o,
  output logic [IDW-1:0]      alloc_id_o,
  input  logic                free_req_i,
  input  logic [IDW-1:0]      free_id_i,
  output logic                free_gnt_o,
  output logic [NB_BARR-1:0]  busy_o,
  output logic                bus_req_o,
  output logic [31:0]         bus_add_o,
  output logic                bus_wen_o,
  output logic [31:0]         bus_wdata_o,
  output logic [3:0]          bus_be_o,
  input  logic                bus_gnt_i,
  input  logic                bus_r_valid_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR_TGT,
    WR_TRIG,
`ifdef BARR_ALLOC_CLR_ON_FREE_EN
    CLR_TGT,
    CLR_TRIG,
`endif
    DONE
  } state_t;

  localparam logic [31:0] TGT_OFS  = 32'h0000_000C;
  localparam logic [31:0] TRIG_OFS = 32'h0000_0000;

  state_t              state_q;
  logic [NB_BARR-1:0]  busy_q;
  logic [IDW-1:0]      cur_id_q;
  logic [NB_CORES-1:0] trig_q;
  logic                free_found;
  logic [IDW-1:0]      free_idx;
  logic                free_id_ok;
  logic                unused_r_valid;

  assign unused_r_valid = bus_r_valid_i;
  assign busy_o         = busy_q;
  assign free_id_ok     = (int'(free_id_i) < NB_BARR);

  // Grants are combinational so a held request is acknowledged in the cycle it is taken.
  assign free_gnt_o  = !rst_i && (state_q == IDLE) && free_req_i;
  assign alloc_gnt_o = !rst_i && (state_q == IDLE) && alloc_req_i && !free_req_i;

  function automatic logic [31:0] barr_addr(input logic [IDW-1:0] id, input logic [31:0] ofs);
    return BASE_ADDR + (32'(id) << 5) + ofs;
  endfunction

  // Scan downward so the lowest-index free barrier wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NB_BARR - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      busy_q       <= '0;
      cur_id_q     <= '0;
      trig_q       <= '0;
      alloc_done_o <= 1'b0;
      alloc_fail_o <= 1'b0;
      alloc_id_o   <= '0;
      bus_req_o    <= 1'b0;
      bus_add_o    <= '0;
      bus_wen_o    <= 1'b1;
      bus_wdata_o  <= '0;
      bus_be_o     <= '0;
    end else begin
      alloc_done_o <= 1'b0;
      alloc_fail_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (free_req_i) begin
            if (free_id_ok) begin
`ifdef BARR_ALLOC_CLR_ON_FREE_EN
              if (busy_q[free_id_i]) begin
                cur_id_q    <= free_id_i;
                bus_req_o   <= 1'b1;
                bus_wen_o   <= 1'b0;
                bus_be_o    <= 4'hF;
                bus_add_o   <= barr_addr(free_id_i, TGT_OFS);
                bus_wdata_o <= '0;
                state_q     <= CLR_TGT;
              end
`else
              busy_q[free_id_i] <= 1'b0;
`endif
            end
          end else if (alloc_req_i) begin
            if (free_found && (alloc_trig_mask_i != '0)) begin
              busy_q[free_idx] <= 1'b1;
              cur_id_q         <= free_idx;
              trig_q           <= alloc_trig_mask_i;
              bus_req_o        <= 1'b1;
              bus_wen_o        <= 1'b0;
              bus_be_o         <= 4'hF;
              bus_add_o        <= barr_addr(free_idx, TGT_OFS);
              bus_wdata_o      <= 32'(alloc_tgt_mask_i);
              state_q          <= WR_TGT;
            end else begin
              alloc_fail_o <= 1'b1;
            end
          end
        end
        WR_TGT: begin
          if (bus_gnt_i) begin
            bus_add_o   <= barr_addr(cur_id_q, TRIG_OFS);
            bus_wdata_o <= 32'(trig_q);
            state_q     <= WR_TRIG;
          end
        end
        WR_TRIG: begin
          if (bus_gnt_i) begin
            bus_req_o    <= 1'b0;
            bus_wen_o    <= 1'b1;
            bus_be_o     <= '0;
            bus_add_o    <= '0;
            bus_wdata_o  <= '0;
            alloc_done_o <= 1'b1;
            alloc_id_o   <= cur_id_q;
            state_q      <= DONE;
          end
        end
`ifdef BARR_ALLOC_CLR_ON_FREE_EN
        CLR_TGT: begin
          if (bus_gnt_i) begin
            bus_add_o <= barr_addr(cur_id_q, TRIG_OFS);
            state_q   <= CLR_TRIG;
          end
        end
        CLR_TRIG: begin
          if (bus_gnt_i) begin
            bus_req_o        <= 1'b0;
            bus_wen_o        <= 1'b1;
            bus_be_o         <= '0;
            bus_add_o        <= '0;
            busy_q[cur_id_q] <= 1'b0;
            state_q          <= IDLE;
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrier_alloc_ctrl.sv
// tb/tb_barrier_alloc_ctrl.sv - table-driven self-checking bench for barrier_alloc_ctrl
module tb_barrier_alloc_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_req_i;
  logic [7:0]  alloc_trig_mask_i;
  logic [7:0]  alloc_tgt_mask_i;
  logic        alloc_gnt_o;
  logic        alloc_done_o;
  logic        alloc_fail_o;
  logic [2:0]  alloc_id_o;
  logic        free_req_i;
  logic [2:0]  free_id_i;
  logic        free_gnt_o;
  logic [7:0]  busy_o;
  logic        bus_req_o;
  logic [31:0] bus_add_o;
  logic        bus_wen_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_r_valid_i;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk_i = ~clk_i;

  barrier_alloc_ctrl #(.NB_CORES(8), .NB_BARR(8), .BASE_ADDR(BASE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_req_i(alloc_req_i), .alloc_trig_mask_i(alloc_trig_mask_i),
    .alloc_tgt_mask_i(alloc_tgt_mask_i), .alloc_gnt_o(alloc_gnt_o),
    .alloc_done_o(alloc_done_o), .alloc_fail_o(alloc_fail_o), .alloc_id_o(alloc_id_o),
    .free_req_i(free_req_i), .free_id_i(free_id_i), .free_gnt_o(free_gnt_o),
    .busy_o(busy_o), .bus_req_o(bus_req_o), .bus_add_o(bus_add_o),
    .bus_wen_o(bus_wen_o), .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_gnt_i(bus_gnt_i), .bus_r_valid_i(bus_r_valid_i)
  );

  typedef struct {
    logic [7:0] trig;
    logic [7:0] tgt;
    logic [2:0] id;
    logic [7:0] busy;
    int         dly;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_alloc(input logic [7:0] trig, input logic [7:0] tgt,
                          input logic [2:0] id, input logic [7:0] busy, input int dly);
    int n;
    logic [31:0] tgt_addr;
    tgt_addr = BASE + 32 * id + 32'h0C;
    @(negedge clk_i);
    free_req_i = 1'b0;
    alloc_req_i = 1'b1; alloc_trig_mask_i = trig; alloc_tgt_mask_i = tgt;
    #1;
    n = 0;
    while (!alloc_gnt_o && n < 10) begin
      @(negedge clk_i); #1; n++;
    end
    chk("alloc_gnt", alloc_gnt_o, 1);
    @(negedge clk_i);
    alloc_req_i = 1'b0;
    bus_gnt_i = (dly == 0);
    #1;
    chk("tgt_req", bus_req_o, 1);
    chk("tgt_wen", bus_wen_o, 0);
    chk("tgt_be", bus_be_o, 4'hF);
    chk("tgt_add", bus_add_o, tgt_addr);
    chk("tgt_wdata", bus_wdata_o, {24'h0, tgt});
    chk("busy_set", busy_o, busy);
    for (int i = 1; i <= dly; i++) begin
      @(negedge clk_i);
      if (i == dly) bus_gnt_i = 1'b1;
      #1;
      chk("stall_add", bus_add_o, tgt_addr);
      chk("stall_wdata", bus_wdata_o, {24'h0, tgt});
      chk("stall_done", alloc_done_o, 0);
    end
    @(negedge clk_i); #1;
    chk("trig_req", bus_req_o, 1);
    chk("trig_add", bus_add_o, BASE + 32 * id);
    chk("trig_wdata", bus_wdata_o, {24'h0, trig});
    chk("early_done", alloc_done_o, 0);
    @(negedge clk_i); #1;
    chk("done", alloc_done_o, 1);
    chk("done_id", alloc_id_o, id);
    chk("done_busreq", bus_req_o, 0);
    @(negedge clk_i); #1;
    chk("done_pulse", alloc_done_o, 0);
  endtask

  task automatic do_fail(input logic [7:0] trig, input logic [7:0] busy);
    @(negedge clk_i);
    alloc_req_i = 1'b1; alloc_trig_mask_i = trig; alloc_tgt_mask_i = 8'hFF;
    #1;
    chk("fail_gnt", alloc_gnt_o, 1);
    chk("fail_early", alloc_fail_o, 0);
    @(negedge clk_i);
    alloc_req_i = 1'b0;
    #1;
    chk("fail_pulse", alloc_fail_o, 1);
    chk("fail_busreq", bus_req_o, 0);
    @(negedge clk_i); #1;
    chk("fail_clear", alloc_fail_o, 0);
    chk("fail_busreq2", bus_req_o, 0);
    chk("fail_busy", busy_o, busy);
  endtask

  task automatic do_free(input logic [2:0] id, input logic [7:0] busy_before,
                         input logic [7:0] busy_after);
    @(negedge clk_i);
    free_req_i = 1'b1; free_id_i = id;
    #1;
    chk("free_gnt", free_gnt_o, 1);
    @(negedge clk_i);
    free_req_i = 1'b0;
    #1;
`ifdef BARR_ALLOC_CLR_ON_FREE_EN
    if (busy_before != busy_after) begin
      chk("clr_tgt_req", bus_req_o, 1);
      chk("clr_tgt_add", bus_add_o, BASE + 32 * id + 32'h0C);
      chk("clr_tgt_wdata", bus_wdata_o, 0);
      chk("clr_busy_hold", busy_o, busy_before);
      @(negedge clk_i); #1;
      chk("clr_trig_add", bus_add_o, BASE + 32 * id);
      chk("clr_trig_wdata", bus_wdata_o, 0);
      chk("clr_busy_hold2", busy_o, busy_before);
      @(negedge clk_i); #1;
    end
`endif
    chk("free_busy", busy_o, busy_after);
    chk("free_busreq", bus_req_o, 0);
  endtask

  initial begin
    vecs[0] = '{8'h0F, 8'h0F, 3'd0, 8'h01, 0};
    vecs[1] = '{8'h01, 8'hFF, 3'd1, 8'h03, 0};
    vecs[2] = '{8'h80, 8'h01, 3'd2, 8'h07, 0};
    vecs[3] = '{8'h3C, 8'hC3, 3'd3, 8'h0F, 5};
    vecs[4] = '{8'hFF, 8'hFF, 3'd4, 8'h1F, 0};
    vecs[5] = '{8'h55, 8'hAA, 3'd5, 8'h3F, 0};
    vecs[6] = '{8'h02, 8'h00, 3'd6, 8'h7F, 1};
    vecs[7] = '{8'h10, 8'h10, 3'd7, 8'hFF, 0};

    rst_i = 1'b1; alloc_req_i = 1'b0; alloc_trig_mask_i = '0; alloc_tgt_mask_i = '0;
    free_req_i = 1'b0; free_id_i = '0; bus_gnt_i = 1'b1; bus_r_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_busreq", bus_req_o, 0);
    chk("rst_wen", bus_wen_o, 1);
    chk("rst_add", bus_add_o, 0);
    chk("rst_wdata", bus_wdata_o, 0);
    chk("rst_be", bus_be_o, 0);
    chk("rst_gnts", {alloc_gnt_o, free_gnt_o}, 0);
    chk("rst_pulses", {alloc_done_o, alloc_fail_o}, 0);
    chk("rst_id", alloc_id_o, 0);
    rst_i = 1'b0;

    for (int v = 0; v < 8; v++)
      do_alloc(vecs[v].trig, vecs[v].tgt, vecs[v].id, vecs[v].busy, vecs[v].dly);

    do_fail(8'h01, 8'hFF);

    // Free and alloc raised together: free must win, then the alloc reuses id 2.
    @(negedge clk_i);
    free_req_i = 1'b1; free_id_i = 3'd2;
    alloc_req_i = 1'b1; alloc_trig_mask_i = 8'h21; alloc_tgt_mask_i = 8'h12;
    #1;
    chk("prio_free_gnt", free_gnt_o, 1);
    chk("prio_alloc_gnt", alloc_gnt_o, 0);
    do_alloc(8'h21, 8'h12, 3'd2, 8'hFF, 0);

    do_free(3'd3, 8'hFF, 8'hF7);
    do_free(3'd3, 8'hF7, 8'hF7);
    do_fail(8'h00, 8'hF7);

    // Reset while the trigger write is in flight.
    @(negedge clk_i);
    alloc_req_i = 1'b1; alloc_trig_mask_i = 8'h0F; alloc_tgt_mask_i = 8'hF0;
    #1;
    chk("rstx_gnt", alloc_gnt_o, 1);
    @(negedge clk_i);
    alloc_req_i = 1'b0;
    @(negedge clk_i); #1;
    chk("rstx_in_trig", bus_add_o, BASE + 32 * 3);
    rst_i = 1'b1;
    #1;
    chk("rstx_busreq", bus_req_o, 0);
    chk("rstx_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rstx_nodone", alloc_done_o, 0);
    @(negedge clk_i); #1;
    chk("rstx_nodone2", alloc_done_o, 0);
    chk("rstx_idle_busreq", bus_req_o, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
